// File: rtl/pattern_filler.sv
// rtl/pattern_filler.sv - LED panel frame-buffer test-pattern generator
//
// Fills the write half of a double-buffered frame memory with one frame of a
// selectable test pattern. When the frame is done, the block hands that half
// to the scan engine through the selected_buffer/actual_buffer handshake.
//
// Ports:
//   clk             - single clock, rising edge
//   rst             - asynchronous reset, active low
//   run             - 1: generate frames; 0: stop at the next frame boundary
//   trigger         - active-low request to advance to the next pattern
//   actual_buffer   - buffer index the scan engine is currently displaying
//   wr_addr         - pixel write address {row, col}
//   wr_data         - pixel data {blue, green, red}
//   wr_ena          - write strobe, one cycle per pixel
//   selected_buffer - buffer being filled / offered for display
//   mode            - active pattern (0 red, 1 green, 2 blue, 3 white,
//                     4 sweep, 5 gradient)
module pattern_filler #(
  parameter int ROW_BITS   = 5,
  parameter int COL_BITS   = 6,
  parameter int CDW        = 8,
  parameter int STEP       = 1,
  parameter int MODE_RESET = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         trigger,
  input  logic                         actual_buffer,
  output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  output logic [3*CDW-1:0]             wr_data,
  output logic                         wr_ena,
  output logic                         selected_buffer,
  output logic [2:0]                   mode
);

  localparam int AW = ROW_BITS + COL_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_NEXT,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [3*CDW-1:0] data_q, data_d;
  logic             ena_q, ena_d;
  logic             sel_q, sel_d;
  logic [2:0]       mode_q, mode_d;
  logic             pending_q, pending_d;
  logic [CDW-1:0]   level_q, level_d;
  logic [AW-1:0]    sweep_q, sweep_d;

  logic [CDW:0]     level_sum;
  logic [AW-1:0]    sweep_next;
  logic [AW-1:0]    addr_inc;
  logic             cycle_done;
  logic             load;

  // Pixel colour for a given pattern state and address.
  function automatic logic [3*CDW-1:0] pixel(
    input logic [2:0]     m,
    input logic [CDW-1:0] lv,
    input logic [AW-1:0]  sw,
    input logic [AW-1:0]  a
  );
    logic [CDW-1:0] r, g, b, col_s, row_s;
    // Column and row are scaled up to full colour range for the gradient.
    col_s = CDW'(a[COL_BITS-1:0]) << (CDW - COL_BITS);
    row_s = CDW'(a[AW-1:COL_BITS]) << (CDW - ROW_BITS);
    r = '0;
    g = '0;
    b = '0;
    case (m)
      3'd0: r = lv;
      3'd1: g = lv;
      3'd2: b = lv;
      3'd3: begin
        r = lv;
        g = lv;
        b = lv;
      end
      3'd4: begin
        if (a == sw) begin
          r = '1;
          g = '1;
          b = '1;
        end
      end
      3'd5: begin
        r = col_s + lv;
        g = row_s;
        b = lv;
      end
      default: ;
    endcase
    return {b, g, r};
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    level_d    = level_q;
    sweep_d    = sweep_q;
    // A request is remembered until a cycle-complete handover consumes it.
    pending_d  = pending_q | ~trigger;
    load       = 1'b0;

    level_sum  = {1'b0, level_q} + (CDW+1)'(STEP);
    sweep_next = sweep_q + 1'b1;
    addr_inc   = addr_q + 1'b1;
    // Only the counter that drives the visible pattern defines a cycle end.
    cycle_done = (mode_q == 3'd4) ? (sweep_next == '0) : level_sum[CDW];

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_WRITE;
          addr_d  = '0;
          load    = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d  = addr_inc;
        load    = 1'b1;
        state_d = (addr_inc == '0) ? S_WAIT : S_WRITE;
      end
      S_WAIT: begin
        if (actual_buffer == sel_q) begin
          sel_d   = ~sel_q;
          addr_d  = '0;
          load    = 1'b1;
          level_d = level_sum[CDW-1:0];
          sweep_d = sweep_next;
          if (cycle_done && pending_q) begin
            mode_d    = (mode_q == 3'd5) ? 3'd0 : mode_q + 3'd1;
            // A trigger still held low here starts a fresh request.
            pending_d = ~trigger;
            level_d   = '0;
            sweep_d   = '0;
          end
          state_d = run ? S_WRITE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ena_d = (state_d == S_WRITE);
    // Data is computed from the post-update pattern state so that the first
    // pixel of a new frame already reflects a mode or level change.
    if (load) begin
      data_d = pixel(mode_d, level_d, sweep_d, addr_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      ena_q     <= 1'b0;
      sel_q     <= 1'b0;
      mode_q    <= 3'(MODE_RESET);
      pending_q <= 1'b0;
      level_q   <= '0;
      sweep_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ena_q     <= ena_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      sweep_q   <= sweep_d;
    end
  end

  assign wr_addr         = addr_q;
  assign wr_data         = data_q;
  assign wr_ena          = ena_q;
  assign selected_buffer = sel_q;
  assign mode            = mode_q;

endmodule

// File: tb/tb_pattern_filler.sv
// tb/tb_pattern_filler.sv - self-checking bench for pattern_filler
module tb_pattern_filler;

  localparam int RB   = 1;
  localparam int CB   = 2;
  localparam int CW   = 8;
  localparam int STP  = 64;
  localparam int NPIX = 8;

  logic          clk = 1'b0;
  logic          rst_n, run, trigger, actual_buffer;
  logic [2:0]    wr_addr;
  logic [23:0]   wr_data;
  logic          wr_ena, selected_buffer;
  logic [2:0]    mode;

  logic          sw_rst_n, sw_run;
  logic [2:0]    sw_addr;
  logic [23:0]   sw_data;
  logic          sw_ena, sw_sel;
  logic [2:0]    sw_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_filler #(.ROW_BITS(RB), .COL_BITS(CB), .CDW(CW), .STEP(STP), .MODE_RESET(0)) dut (
    .clk(clk), .rst(rst_n), .run(run), .trigger(trigger), .actual_buffer(actual_buffer),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ena(wr_ena),
    .selected_buffer(selected_buffer), .mode(mode)
  );

  // Sweep instance with the scan engine always following the offered buffer.
  pattern_filler #(.ROW_BITS(RB), .COL_BITS(CB), .CDW(CW), .STEP(STP), .MODE_RESET(4)) dut_sw (
    .clk(clk), .rst(sw_rst_n), .run(sw_run), .trigger(1'b1), .actual_buffer(sw_sel),
    .wr_addr(sw_addr), .wr_data(sw_data), .wr_ena(sw_ena),
    .selected_buffer(sw_sel), .mode(sw_mode)
  );

  typedef struct {
    bit trig;
    int stall;
    int m;
    int lv;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference pixel from the pattern definitions, in plain integer arithmetic.
  function automatic logic [23:0] ref_pix(input int m, input int lv, input int sw, input int a);
    int r, g, b, row, col;
    row = a / 4;
    col = a % 4;
    r = 0;
    g = 0;
    b = 0;
    case (m)
      0: r = lv;
      1: g = lv;
      2: b = lv;
      3: begin r = lv; g = lv; b = lv; end
      4: if (a == sw) begin r = 255; g = 255; b = 255; end
      5: begin r = (col * 64 + lv) % 256; g = row * 128; b = lv; end
      default: ;
    endcase
    return {8'(b), 8'(g), 8'(r)};
  endfunction

  task automatic start_run();
    bit found;
    found = 1'b0;
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (wr_ena) begin
        found = 1'b1;
        break;
      end
    end
    check("start_latency", 64'(found), 64'(1));
  endtask

  // Entered at the negedge where the frame's first write is visible; leaves at
  // the negedge where the next frame's first write should be visible.
  task automatic do_frame(input int m, input int lv, input int sw, input bit trig,
                          input int stall, input bit keep_run, input int reset_at,
                          input bit exp_sel);
    int hold;
    for (int i = 0; i < NPIX; i++) begin
      if (i > 0) begin
        @(negedge clk);
        trigger = 1'b1;
        check("gap_low", 64'(wr_ena), 64'(0));
        @(negedge clk);
      end
      check("write", 64'({wr_ena, wr_addr, wr_data, selected_buffer, mode}),
            64'({1'b1, 3'(i), ref_pix(m, lv, sw, i), exp_sel, 3'(m)}));
      if (i == 0) actual_buffer = (stall == 0) ? exp_sel : ~exp_sel;
      if (trig && i == 3) trigger = 1'b0;
      if (!keep_run && i == 3) run = 1'b0;
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 64'({wr_ena, wr_addr, wr_data, selected_buffer, mode}), 64'(0));
        return;
      end
    end
    hold = (stall < 2) ? 2 : stall;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      check("tail_idle", 64'({wr_ena, selected_buffer}), 64'({1'b0, exp_sel}));
      if (k == stall) actual_buffer = exp_sel;
    end
    @(negedge clk);
    if (keep_run) begin
      check("handover", 64'({wr_ena, wr_addr, selected_buffer}), 64'({1'b1, 3'd0, ~exp_sel}));
    end else begin
      check("handover_stop", 64'({wr_ena, selected_buffer}), 64'({1'b0, ~exp_sel}));
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stopped", 64'(wr_ena), 64'(0));
      end
    end
  endtask

  initial begin
    int m, lv, sw, nframes;
    bit pend, sel, trig, complete, seen_ena, got;
    int st;

    tbl[0] = '{1'b0, 0,  0, 0};
    tbl[1] = '{1'b1, 0,  0, 64};
    tbl[2] = '{1'b0, 20, 0, 128};
    tbl[3] = '{1'b0, 0,  0, 192};
    tbl[4] = '{1'b0, 3,  1, 0};
    tbl[5] = '{1'b0, 0,  1, 64};

    rst_n = 1'b0;
    run = 1'b0;
    trigger = 1'b1;
    actual_buffer = 1'b0;
    sw_rst_n = 1'b0;
    sw_run = 1'b0;

    // Reset and idle behaviour.
    @(negedge clk);
    check("reset_state", 64'({wr_ena, wr_addr, wr_data, selected_buffer, mode}), 64'(0));
    rst_n = 1'b1;
    seen_ena = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wr_ena) seen_ena = 1'b1;
    end
    check("idle_no_write", 64'(seen_ena), 64'(0));
    check("idle_sel_mode", 64'({selected_buffer, mode}), 64'(0));

    // Table-driven frames: level ramp, stalls, and a trigger-driven mode advance.
    start_run();
    for (int r = 0; r < 6; r++) begin
      do_frame(tbl[r].m, tbl[r].lv, 0, tbl[r].trig, tbl[r].stall, 1'b1, -1, 1'(r % 2));
    end

    // Drop run mid-frame, then reset in the middle of a later frame.
    do_frame(1, 128, 0, 1'b0, 0, 1'b0, -1, 1'b0);
    start_run();
    do_frame(1, 192, 0, 1'b0, 0, 1'b1, 5, 1'b1);
    run = 1'b0;
    trigger = 1'b1;
    actual_buffer = 1'b0;
    @(negedge clk);
    check("reset_hold", 64'({wr_ena, wr_addr, wr_data, selected_buffer, mode}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised frames against a frame-level model.
    m = 0; lv = 0; sw = 0; pend = 1'b0; sel = 1'b0;
    nframes = 60;
    start_run();
    for (int f = 0; f < nframes; f++) begin
      trig = ($urandom % 2) == 0;
      st = (($urandom % 3) == 0) ? int'($urandom_range(6, 1)) : 0;
      do_frame(m, lv, sw, trig, st, (f != nframes - 1), -1, sel);
      complete = (m == 4) ? (((sw + 1) % NPIX) == 0) : ((lv + STP) >= 256);
      if (trig) pend = 1'b1;
      lv = (lv + STP) % 256;
      sw = (sw + 1) % NPIX;
      if (complete && pend) begin
        m = (m + 1) % 6;
        pend = 1'b0;
        lv = 0;
        sw = 0;
      end
      sel = ~sel;
    end

    // Sweep instance: frame k lights exactly address k mod 8.
    sw_rst_n = 1'b1;
    @(negedge clk);
    sw_run = 1'b1;
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (sw_ena) begin
            got = 1'b1;
            break;
          end
        end
        check("sweep_write", 64'({got, sw_addr, sw_data, sw_mode}),
              64'({1'b1, 3'(i), (i == f % NPIX) ? 24'hFFFFFF : 24'h0, 3'd4}));
      end
    end
    sw_run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
